// File: rtl/pair_lane_rx.sv
// Two-lane serial frame receiver: frames on SOF, assembles DATA_BEATS lane pairs
// into a word, checks parity/stop, and hands good words to a one-entry output register.
module pair_lane_rx #(
  parameter int DATA_BEATS = 4,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [1:0]              in_bits,
  output logic                    out_valid,
  output logic [2*DATA_BEATS-1:0] out_data,
  input  logic                    out_ready,
  output logic                    frame_err,
  output logic                    overflow
);

  localparam int W  = 2 * DATA_BEATS;
  localparam int CW = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(DATA_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    asm_q, asm_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  logic            word_good;
  logic            drain;

  // Frame FSM: only qualified beats advance; SOF always wins and restarts the frame.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    frame_err_d = 1'b0;
    word_good   = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        frame_err_d = (state_q != S_IDLE);
        state_d     = S_DATA;
        cnt_d       = '0;
        asm_d       = '0;
      end else begin
        case (state_q)
          S_DATA: begin
            // Pairs enter at the top and shift down, so beat 0 ends up in bits [1:0].
            asm_d = (asm_q >> 2) | (W'(in_bits) << (W - 2));
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST_BEAT) begin
              state_d = S_CHECK;
              cnt_d   = '0;
            end
          end
          S_CHECK: begin
            state_d = S_IDLE;
            if (in_bits[1] && (!PARITY_EN || ((^asm_q) == in_bits[0]))) begin
              word_good = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    drain       = out_valid_q & out_ready;
    out_valid_d = out_valid_q & ~drain;
    out_data_d  = out_data_q;
    overflow_d  = overflow_q;
    if (word_good) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        out_data_d  = asm_q;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      asm_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pair_lane_rx.sv
// Scoreboard bench for pair_lane_rx: stimulus builds frames and predicts their outcome,
// a monitor checks every delivered word, error pulse and status flag against that prediction.
module tb_pair_lane_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic [1:0]   in_bits = 2'b00;
  logic         out_ready = 1'b1;
  logic         out_valid, frame_err, overflow;
  logic [W-1:0] out_data;
  logic         np_out_valid, np_frame_err, np_overflow;
  logic [W-1:0] np_out_data;

  pair_lane_rx #(.DATA_BEATS(4), .PARITY_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_bits(in_bits),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  pair_lane_rx #(.DATA_BEATS(4), .PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_bits(in_bits),
    .out_valid(np_out_valid), .out_data(np_out_data), .out_ready(out_ready),
    .frame_err(np_frame_err), .overflow(np_overflow)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  bit           mon_en = 1'b0;
  bit           rand_rdy = 1'b0;
  logic         arrive = 1'b0;
  logic [W-1:0] arr_data = '0;
  logic         m_full, m_ovf;
  logic [W-1:0] exp_q[$];
  int           err_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // One-slot output buffer model: a good word arriving finds the slot free (or
  // being emptied this cycle) and is queued for delivery, otherwise it is lost.
  always @(posedge clk) begin
    if (rst) begin
      m_full <= 1'b0;
      m_ovf  <= 1'b0;
      exp_q.delete();
    end else if (arrive) begin
      if (!m_full || out_ready) begin
        m_full <= 1'b1;
        exp_q.push_back(arr_data);
      end else begin
        m_ovf <= 1'b1;
      end
    end else if (m_full && out_ready) begin
      m_full <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("out_valid", out_valid, m_full);
      chk("overflow", overflow, m_ovf);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL word_unexpected actual=%0h required=none", out_data);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (frame_err) begin
        if (err_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_err_spurious actual=1 required=0 cycle=%0d", cyc);
        end else begin
          chk("frame_err_cycle", cyc, err_q.pop_front());
        end
      end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL frame_err_missing actual=0 required=1 cycle=%0d", err_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    arrive = 1'b0;
    if (rand_rdy) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_sof   = 1'($urandom);
    in_bits  = 2'($urandom);
    step();
  endtask

  task automatic beat(input logic sof, input logic [1:0] bits, input bit arr,
                      input logic [W-1:0] d, input bit err);
    in_valid = 1'b1;
    in_sof   = sof;
    in_bits  = bits;
    arrive   = arr;
    arr_data = d;
    step();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (err) err_q.push_back(cyc);
  endtask

  task automatic gap(input bit g);
    if (g) repeat ($urandom_range(2)) idle_cycle();
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic [1:0] chkb, input bit g,
                            input bit abort, input bit rdy_chk);
    bit good;
    gap(g);
    beat(1'b1, 2'($urandom), 1'b0, '0, abort);
    for (int k = 0; k < W / 2; k++) begin
      gap(g);
      beat(1'b0, w[2*k +: 2], 1'b0, '0, 1'b0);
    end
    gap(g);
    good = chkb[1] && ((^w) == chkb[0]);
    if (rdy_chk) out_ready = 1'b1;
    beat(1'b0, chkb, good, w, !good);
  endtask

  task automatic partial(input int n);
    beat(1'b1, 2'b00, 1'b0, '0, 1'b0);
    for (int k = 0; k < n; k++) beat(1'b0, 2'($urandom), 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    err_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    logic [1:0]   cb;
    bit           ab;
    repeat (2) step();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, 8'h00);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_overflow", overflow, 1'b0);
    mon_en = 1'b1;
    step();

    send_frame(8'hA5, 2'b10, 1'b0, 1'b0, 1'b0);
    repeat (2) idle_cycle();

    send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    chk("noparity_valid", np_out_valid, 1'b1);
    chk("noparity_data", np_out_data, 8'hA5);
    repeat (2) idle_cycle();

    send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) idle_cycle();

    partial(2);
    send_frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b0);
    repeat (2) idle_cycle();

    out_ready = 1'b0;
    send_frame(8'h11, 2'b10, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 2'b10, 1'b0, 1'b0, 1'b0);
    chk("ovf_held_data", out_data, 8'h11);
    chk("ovf_sticky", overflow, 1'b1);
    out_ready = 1'b1;
    repeat (2) idle_cycle();
    do_reset();

    out_ready = 1'b0;
    send_frame(8'h11, 2'b10, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 2'b10, 1'b0, 1'b0, 1'b1);
    chk("drain_load_data", out_data, 8'h22);
    repeat (2) idle_cycle();
    chk("drain_no_overflow", overflow, 1'b0);

    send_frame(8'hC3, 2'b10, 1'b1, 1'b0, 1'b0);
    repeat (2) idle_cycle();

    partial(2);
    do_reset();
    send_frame(8'h5A, 2'b10, 1'b0, 1'b0, 1'b0);
    repeat (2) idle_cycle();

    rand_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      w  = 8'($urandom);
      cb = ($urandom_range(4) == 0) ? 2'($urandom) : {1'b1, ^w};
      ab = 1'b0;
      if ($urandom_range(7) == 0) beat(1'b0, 2'($urandom), 1'b0, '0, 1'b0);
      if ($urandom_range(7) == 0) begin
        partial($urandom_range(4));
        ab = 1'b1;
      end
      send_frame(w, cb, 1'($urandom), ab, 1'b0);
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    repeat (4) idle_cycle();
    chk("words_outstanding", exp_q.size(), 0);
    chk("errors_outstanding", err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
